ofm_write_addr_gen: RTL and testbench
=====================================

Name: ofm_write_addr_gen

Overview:
- Downstream of the main controller. Consumes the OFM write beats: write_ofm_en plus one packed row of systolic-array outputs per beat.
- Generates OFM memory word addresses, lane masks and completion flags for one filter group, in the order the controller emits tiles.
- One beat carries SYSTOLIC_SIZE horizontally adjacent output pixels belonging to one filter.

Parameters:
- SYSTOLIC_SIZE, 16, array dimension; pixels per beat and beats per tile.
- OFM_SIZE, 32, OFM height and width.
- NO_FILTER, 16, total filters; OFM planes in memory.
- DATA_WIDTH, 16, bits per output pixel.
- ADDR_WIDTH, 14, pixel address width; must be >= clog2(NO_FILTER*OFM_SIZE*OFM_SIZE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  pulse; clears counters and flags, latches filter_group, enters ACTIVE.
- filter_group  in  7  0-based filter group; filter base = filter_group*SYSTOLIC_SIZE.
- in_valid  in  1  beat valid (driven by write_ofm_en).
- in_data  in  SYSTOLIC_SIZE*DATA_WIDTH  beat payload; lane 0 in the LSBs.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  pixel address of lane 0.
- mem_data  out  SYSTOLIC_SIZE*DATA_WIDTH  registered copy of in_data.
- mem_lane_en  out  SYSTOLIC_SIZE  per-lane write enable.
- tile_done  out  1  pulse with the last beat of each tile.
- group_done  out  1  level, high in DONE.
- overflow_err  out  1  sticky; a beat arrived outside ACTIVE.

Interface decision: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Derived constants:
  - NTPL = ceil(OFM_SIZE/SYSTOLIC_SIZE).
  - Tiles per group = NTPL*OFM_SIZE.
  - Beats per tile = SYSTOLIC_SIZE.
- Counters:
  - k: beat index within tile, 0..SYSTOLIC_SIZE-1.
  - tcol: tile column, 0..NTPL-1.
  - row: 0..OFM_SIZE-1.
  - Nesting: k innermost, then tcol, then row. Each advances only on an accepted beat (in_valid in ACTIVE); each wraps to 0 and carries.
- States:
  - IDLE: waits for start, then goes to ACTIVE.
  - ACTIVE: accepts beats; goes to DONE on the beat with k=S-1, tcol=NTPL-1, row=OFM_SIZE-1.
  - DONE: waits for start, then goes to ACTIVE.
- start in any state, including mid-group in ACTIVE: next state ACTIVE, counters 0, overflow_err 0, filter_group re-latched. An in_valid in the same cycle as start is dropped and does not set overflow_err.
- Latency: one cycle, fully registered. An accepted beat in cycle N gives mem_wr_en/mem_addr/mem_data/mem_lane_en in cycle N+1.
- Address:
  - mem_addr = f*OFM_SIZE*OFM_SIZE + row*OFM_SIZE + tcol*SYSTOLIC_SIZE, where f = base + k.
  - Computed at full internal width, then truncated to ADDR_WIDTH.
- Lane mask: lane j enabled iff tcol*SYSTOLIC_SIZE + j < OFM_SIZE.
- Filter bound: if f >= NO_FILTER, mem_wr_en=0 and mem_lane_en=0 for that beat; counters still advance. The tile_done/group_done timing is unaffected.
- mem_wr_en is 0 in any cycle without an accepted beat. mem_addr and mem_data hold their last values.
- tile_done: high in the same cycle as the output of a k=S-1 beat.
- group_done:
  - Rises in the same cycle as the final output beat.
  - Stays high until start or reset.
- Beat arriving in IDLE or DONE: ignored (no write, no counter change); overflow_err set next cycle.
- Async reset mid-operation: immediate return to reset values.

Test Plan:
- Default params; start, group 0, 1024 consecutive beats -> addresses in order:
  - beats 0, 1, 15 -> 0, 1024, 15360;
  - beat 16 -> 16; beat 32 -> 32;
  - last beat -> 16368, with tile_done=1 and group_done=1 in the same cycle;
  - 64 tile_done pulses total.
- Default params; beats with random in_valid gaps -> address sequence identical to the gap-free case; mem_wr_en low in every gap cycle; mem_data equals in_data delayed by 1 cycle.
- OFM_SIZE=20, NO_FILTER=20; group 1 -> tcol 1 beats have mem_lane_en=16'h000F; beats k=4..15 have mem_wr_en=0. First write of group 1: f=16, addr=6400; 40 tiles then group_done.
- in_valid in IDLE -> no write; overflow_err=1 next cycle. Then start -> overflow_err=0, and the first beat writes addr 0.
- start after 100 beats (mid-group), then a beat -> addr 0; group_done stays 0.
- rst_n low for 1 cycle mid-group -> all outputs 0 immediately; subsequent in_valid sets overflow_err, with no write.

Source files
------------

// File: rtl/ofm_write_addr_gen_if.sv
// Beat-in / memory-write-out bus of the OFM write address generator.
// The master side feeds beats and observes writes; the slave side is the generator.
interface ofm_write_addr_gen_if #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 14
);
  logic                                  in_valid;
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   in_data;
  logic                                  mem_wr_en;
  logic [ADDR_WIDTH-1:0]                 mem_addr;
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   mem_data;
  logic [SYSTOLIC_SIZE-1:0]              mem_lane_en;

  modport master (
    output in_valid, in_data,
    input  mem_wr_en, mem_addr, mem_data, mem_lane_en
  );

  modport slave (
    input  in_valid, in_data,
    output mem_wr_en, mem_addr, mem_data, mem_lane_en
  );
endinterface

// File: rtl/ofm_write_addr_gen.sv
// Turns a stream of systolic-array output rows into OFM memory writes for one filter group,
// walking beat (filter) innermost, then tile column, then OFM row.
module ofm_write_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_SIZE      = 32,
  parameter int NO_FILTER     = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            filter_group,
  ofm_write_addr_gen_if.slave   bus,
  output logic                  tile_done,
  output logic                  group_done,
  output logic                  overflow_err
);

  localparam int NTPL = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int KW   = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int TW   = (NTPL > 1) ? $clog2(NTPL) : 1;
  localparam int RW   = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam int LW   = SYSTOLIC_SIZE * DATA_WIDTH;

  localparam logic [KW-1:0] K_LAST = KW'(SYSTOLIC_SIZE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NTPL - 1);
  localparam logic [RW-1:0] R_LAST = RW'(OFM_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [TW-1:0]            tcol_q, tcol_d;
  logic [RW-1:0]            row_q, row_d;
  logic [6:0]               fgroup_q, fgroup_d;
  logic                     mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [LW-1:0]            mem_data_q, mem_data_d;
  logic [SYSTOLIC_SIZE-1:0] mem_lane_en_q, mem_lane_en_d;
  logic                     tile_done_q, tile_done_d;
  logic                     group_done_q, group_done_d;
  logic                     overflow_err_q, overflow_err_d;

  logic [31:0]              f_idx;
  logic                     f_in_range;
  logic [SYSTOLIC_SIZE-1:0] lane_mask;
  logic                     accept;
  logic                     last_k, last_t, last_r;

  // Filter of the current beat and whether it exists in memory
  always_comb begin
    f_idx      = 32'(fgroup_q) * 32'(SYSTOLIC_SIZE) + 32'(k_q);
    f_in_range = f_idx < 32'(NO_FILTER);
  end

  // Lanes of the last tile column may hang past the right edge of the OFM
  always_comb begin
    lane_mask = '0;
    for (int j = 0; j < SYSTOLIC_SIZE; j++) begin
      lane_mask[j] = (32'(tcol_q) * 32'(SYSTOLIC_SIZE) + 32'(j)) < 32'(OFM_SIZE);
    end
  end

  always_comb begin
    accept = (state_q == ACTIVE) && bus.in_valid && !start;
    last_k = (k_q == K_LAST);
    last_t = (tcol_q == T_LAST);
    last_r = (row_q == R_LAST);
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    tcol_d         = tcol_q;
    row_d          = row_q;
    fgroup_d       = fgroup_q;
    mem_wr_en_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    mem_lane_en_d  = '0;
    tile_done_d    = 1'b0;
    group_done_d   = group_done_q;
    overflow_err_d = overflow_err_q;

    if (start) begin
      // Restart wins over everything, including a beat in the same cycle
      state_d        = ACTIVE;
      k_d            = '0;
      tcol_d         = '0;
      row_d          = '0;
      fgroup_d       = filter_group;
      group_done_d   = 1'b0;
      overflow_err_d = 1'b0;
    end else if (bus.in_valid && (state_q != ACTIVE)) begin
      overflow_err_d = 1'b1;
    end else if (accept) begin
      mem_wr_en_d   = f_in_range;
      mem_lane_en_d = f_in_range ? lane_mask : '0;
      mem_addr_d    = ADDR_WIDTH'(f_idx * 32'(OFM_SIZE * OFM_SIZE)
                                  + 32'(row_q) * 32'(OFM_SIZE)
                                  + 32'(tcol_q) * 32'(SYSTOLIC_SIZE));
      mem_data_d    = bus.in_data;
      tile_done_d   = last_k;

      if (last_k) begin
        k_d = '0;
        if (last_t) begin
          tcol_d = '0;
          if (last_r) begin
            row_d        = '0;
            state_d      = DONE;
            group_done_d = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          tcol_d = tcol_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      k_q            <= '0;
      tcol_q         <= '0;
      row_q          <= '0;
      fgroup_q       <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_lane_en_q  <= '0;
      tile_done_q    <= 1'b0;
      group_done_q   <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      tcol_q         <= tcol_d;
      row_q          <= row_d;
      fgroup_q       <= fgroup_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      mem_lane_en_q  <= mem_lane_en_d;
      tile_done_q    <= tile_done_d;
      group_done_q   <= group_done_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_lane_en = mem_lane_en_q;
  assign tile_done       = tile_done_q;
  assign group_done      = group_done_q;
  assign overflow_err    = overflow_err_q;

endmodule

// File: tb/tb_ofm_write_addr_gen.sv
// Directed bench for ofm_write_addr_gen: a default 32x32/16-filter instance and a
// 20x20/20-filter instance that exercises partial lane masks and the filter bound.
module tb_ofm_write_addr_gen;
  localparam int S  = 16;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int LW = S * DW;

  typedef struct {
    logic          start;
    logic [6:0]    fg;
    logic          in_valid;
    logic [LW-1:0] in_data;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [S-1:0]  exp_lane;
    logic          exp_td;
    logic          exp_gd;
    logic          exp_ovf;
    logic [LW-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start20;
  logic [6:0] fg, fg20;
  logic td, gd, ovf, td20, gd20, ovf20;

  int checks = 0;
  int failures = 0;
  int td_count, td20_count;

  logic [AW-1:0] hold_addr;
  logic [LW-1:0] hold_data;
  logic          hold_gd;

  always #5 clk = ~clk;

  ofm_write_addr_gen_if #(.SYSTOLIC_SIZE(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ofm_write_addr_gen_if #(.SYSTOLIC_SIZE(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus20 ();

  ofm_write_addr_gen #(
    .SYSTOLIC_SIZE(S), .OFM_SIZE(32), .NO_FILTER(16), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter_group(fg), .bus(bus),
    .tile_done(td), .group_done(gd), .overflow_err(ovf)
  );

  ofm_write_addr_gen #(
    .SYSTOLIC_SIZE(S), .OFM_SIZE(20), .NO_FILTER(20), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start20), .filter_group(fg20), .bus(bus20),
    .tile_done(td20), .group_done(gd20), .overflow_err(ovf20)
  );

  task automatic checkVal(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] randData();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mkVec(input logic st, input logic [6:0] g, input logic v,
                                 input logic [LW-1:0] d, input logic wr, input logic [AW-1:0] a,
                                 input logic [S-1:0] ln, input logic t, input logic gdn,
                                 input logic o, input logic [LW-1:0] ed);
    vec_t r;
    r.start = st; r.fg = g; r.in_valid = v; r.in_data = d;
    r.exp_wr = wr; r.exp_addr = a; r.exp_lane = ln; r.exp_td = t;
    r.exp_gd = gdn; r.exp_ovf = o; r.exp_data = ed;
    return r;
  endfunction

  // Expected address of beat n for group 0 on the 32x32 instance
  function automatic logic [AW-1:0] modelAddr(input int n);
    int k, tcol, row;
    k    = n % S;
    tcol = (n / S) % 2;
    row  = n / (S * 2);
    return AW'(k * 1024 + row * 32 + tcol * S);
  endfunction

  task automatic applyStimulus(input vec_t v);
    start        = v.start;
    fg           = v.fg;
    bus.in_valid = v.in_valid;
    bus.in_data  = v.in_data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, ".wr_en"}, LW'(bus.mem_wr_en), LW'(v.exp_wr));
    checkVal({tag, ".addr"}, LW'(bus.mem_addr), LW'(v.exp_addr));
    checkVal({tag, ".lane_en"}, LW'(bus.mem_lane_en), LW'(v.exp_lane));
    checkVal({tag, ".tile_done"}, LW'(td), LW'(v.exp_td));
    checkVal({tag, ".group_done"}, LW'(gd), LW'(v.exp_gd));
    checkVal({tag, ".overflow"}, LW'(ovf), LW'(v.exp_ovf));
    checkVal({tag, ".data"}, bus.mem_data, v.exp_data);
  endtask

  task automatic runBeat(input int n, input logic valid, input logic [LW-1:0] d, input string tag);
    vec_t v;
    v = mkVec(1'b0, 7'd0, valid, d, 1'b0, hold_addr, '0, 1'b0, hold_gd, 1'b0, hold_data);
    if (valid) begin
      v.exp_wr   = 1'b1;
      v.exp_addr = modelAddr(n);
      v.exp_lane = '1;
      v.exp_td   = (n % S == S - 1);
      v.exp_gd   = (n == 1023);
      v.exp_data = d;
      hold_addr  = v.exp_addr;
      hold_data  = d;
      if (n == 1023) hold_gd = 1'b1;
    end
    applyStimulus(v);
    checkOutput(v, tag);
    if (td) td_count++;
  endtask

  task automatic startCycle(input logic valid, input string tag);
    vec_t v;
    v = mkVec(1'b1, 7'd0, valid, randData(), 1'b0, hold_addr, '0, 1'b0, 1'b0, 1'b0, hold_data);
    hold_gd = 1'b0;
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".wr_en"}, LW'(bus.mem_wr_en), '0);
    checkVal({tag, ".addr"}, LW'(bus.mem_addr), '0);
    checkVal({tag, ".lane_en"}, LW'(bus.mem_lane_en), '0);
    checkVal({tag, ".tile_done"}, LW'(td), '0);
    checkVal({tag, ".group_done"}, LW'(gd), '0);
    checkVal({tag, ".overflow"}, LW'(ovf), '0);
    checkVal({tag, ".data"}, bus.mem_data, '0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    logic [LW-1:0] dv[8];
    int spot_n[6];
    logic [AW-1:0] spot_a[6];
    int n;
    logic valid;
    logic [LW-1:0] d;

    for (int i = 0; i < 8; i++) dv[i] = {S{DW'(16'h1111 * (i + 1))}};
    // idle beat, start with dropped beat, two beats, gap, beat, restart, first beat again
    tbl[0] = mkVec(1'b0, 7'd0, 1'b1, dv[0], 1'b0, 14'd0,    16'h0000, 1'b0, 1'b0, 1'b1, '0);
    tbl[1] = mkVec(1'b1, 7'd0, 1'b1, dv[1], 1'b0, 14'd0,    16'h0000, 1'b0, 1'b0, 1'b0, '0);
    tbl[2] = mkVec(1'b0, 7'd0, 1'b1, dv[2], 1'b1, 14'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0, dv[2]);
    tbl[3] = mkVec(1'b0, 7'd0, 1'b1, dv[3], 1'b1, 14'd1024, 16'hFFFF, 1'b0, 1'b0, 1'b0, dv[3]);
    tbl[4] = mkVec(1'b0, 7'd0, 1'b0, dv[4], 1'b0, 14'd1024, 16'h0000, 1'b0, 1'b0, 1'b0, dv[3]);
    tbl[5] = mkVec(1'b0, 7'd0, 1'b1, dv[5], 1'b1, 14'd2048, 16'hFFFF, 1'b0, 1'b0, 1'b0, dv[5]);
    tbl[6] = mkVec(1'b1, 7'd0, 1'b0, dv[6], 1'b0, 14'd2048, 16'h0000, 1'b0, 1'b0, 1'b0, dv[5]);
    tbl[7] = mkVec(1'b0, 7'd0, 1'b1, dv[7], 1'b1, 14'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0, dv[7]);

    spot_n = '{0, 1, 15, 16, 32, 1023};
    spot_a = '{14'd0, 14'd1024, 14'd15360, 14'd16, 14'd32, 14'd16368};

    rst_n = 1'b0;
    start = 1'b0; fg = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    start20 = 1'b0; fg20 = '0; bus20.in_valid = 1'b0; bus20.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], $sformatf("vec%0d", i));
    end
    hold_addr = 14'd0;
    hold_data = dv[7];
    hold_gd   = 1'b0;

    $display("[TB] full group without gaps");
    startCycle(1'b0, "start_full");
    td_count = 0;
    for (int b = 0; b < 1024; b++) begin
      runBeat(b, 1'b1, randData(), $sformatf("full%0d", b));
      for (int i = 0; i < 6; i++)
        if (spot_n[i] == b) checkVal($sformatf("spot_beat%0d", b), LW'(bus.mem_addr), LW'(spot_a[i]));
    end
    checkVal("tile_done_count", LW'(td_count), LW'(64));

    v = mkVec(1'b0, 7'd0, 1'b1, randData(), 1'b0, hold_addr, '0, 1'b0, 1'b1, 1'b1, hold_data);
    applyStimulus(v);
    checkOutput(v, "beat_in_done");

    $display("[TB] full group with random gaps");
    startCycle(1'b1, "start_gaps");
    td_count = 0;
    n = 0;
    while (n < 1024) begin
      valid = ($urandom_range(0, 2) != 0);
      runBeat(n, valid, randData(), $sformatf("gap%0d", n));
      if (valid) n++;
    end
    checkVal("tile_done_count_gaps", LW'(td_count), LW'(64));

    $display("[TB] restart mid-group");
    startCycle(1'b0, "start_mid");
    for (int b = 0; b < 100; b++) runBeat(b, 1'b1, randData(), $sformatf("mid%0d", b));
    startCycle(1'b1, "restart");
    for (int b = 0; b < 3; b++) runBeat(b, 1'b1, randData(), $sformatf("after_restart%0d", b));

    $display("[TB] async reset mid-group");
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_addr = '0; hold_data = '0; hold_gd = 1'b0;
    v = mkVec(1'b0, 7'd0, 1'b1, randData(), 1'b0, 14'd0, '0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(v);
    checkOutput(v, "beat_after_reset");

    $display("[TB] 20x20 instance, group 1");
    start20 = 1'b1; fg20 = 7'd1;
    @(posedge clk);
    #1;
    start20 = 1'b0;
    td20_count = 0;
    for (int b = 0; b < 640; b++) begin
      int k, tcol, row, f;
      logic wr;
      k    = b % S;
      tcol = (b / S) % 2;
      row  = b / (S * 2);
      f    = 16 + k;
      wr   = (f < 20);
      d    = randData();
      bus20.in_valid = 1'b1;
      bus20.in_data  = d;
      @(posedge clk);
      #1;
      checkVal($sformatf("g1_%0d.wr_en", b), LW'(bus20.mem_wr_en), LW'(wr));
      checkVal($sformatf("g1_%0d.lane_en", b), LW'(bus20.mem_lane_en),
               LW'(!wr ? 16'h0000 : (tcol == 0 ? 16'hFFFF : 16'h000F)));
      if (wr) begin
        checkVal($sformatf("g1_%0d.addr", b), LW'(bus20.mem_addr), LW'(f * 400 + row * 20 + tcol * 16));
        checkVal($sformatf("g1_%0d.data", b), bus20.mem_data, d);
      end
      if (b == 0) checkVal("g1_first_addr", LW'(bus20.mem_addr), LW'(6400));
      checkVal($sformatf("g1_%0d.tile_done", b), LW'(td20), LW'(k == S - 1));
      checkVal($sformatf("g1_%0d.group_done", b), LW'(gd20), LW'(b == 639));
      if (td20) td20_count++;
    end
    bus20.in_valid = 1'b0;
    checkVal("g1_tile_done_count", LW'(td20_count), LW'(40));
    @(posedge clk);
    #1;
    checkVal("g1_group_done_hold", LW'(gd20), LW'(1));
    checkVal("g1_idle_wr_en", LW'(bus20.mem_wr_en), LW'(0));
    checkVal("g1_overflow", LW'(ovf20), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
